// File: rtl/cd_config_initiator_pkg.sv
// Shared constants for the clock-divider configuration initiator:
// bus widths, target addresses, config codes, error codes and FSM states.
package cd_config_initiator_pkg;

    localparam int WIDTH_CONFIG_ADDR = 2;
    localparam int WIDTH_CONFIG_DATA = 8;

    localparam logic [1:0] UART_BAUDRATE_ADDR  = 2'b01;
    localparam logic [1:0] VGA_RESOLUTION_ADDR = 2'b10;

    localparam logic [7:0] BAUDRATE_1200   = 8'h00;
    localparam logic [7:0] BAUDRATE_2400   = 8'h01;
    localparam logic [7:0] BAUDRATE_4800   = 8'h02;
    localparam logic [7:0] BAUDRATE_9600   = 8'h03;
    localparam logic [7:0] BAUDRATE_19200  = 8'h04;
    localparam logic [7:0] BAUDRATE_38400  = 8'h05;
    localparam logic [7:0] BAUDRATE_57600  = 8'h06;
    localparam logic [7:0] BAUDRATE_115200 = 8'h07;

    localparam logic [7:0] VGA_640x480   = 8'h00;
    localparam logic [7:0] VGA_800x600   = 8'h01;
    localparam logic [7:0] VGA_1024x768  = 8'h02;
    localparam logic [7:0] VGA_1280x1024 = 8'h03;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BAD_ADDR = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RDY  = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    // Only the UART and VGA targets exist on the config bus.
    function automatic logic addr_ok(input logic [1:0] addr);
        return (addr == UART_BAUDRATE_ADDR) || (addr == VGA_RESOLUTION_ADDR);
    endfunction

endpackage

// File: rtl/cd_config_initiator_if.sv
// Request side and config-bus side of the initiator in one bundle.
// master = initiator view, slave = upstream logic plus divider targets.
interface cd_config_initiator_if #(
    parameter int WIDTH_CONFIG_ADDR = 2,
    parameter int WIDTH_CONFIG_DATA = 8
);

    logic                         req_valid;
    logic                         req_ready;
    logic [WIDTH_CONFIG_ADDR-1:0] req_addr;
    logic [WIDTH_CONFIG_DATA-1:0] req_data;

    logic [WIDTH_CONFIG_ADDR-1:0] c_addr;
    logic [WIDTH_CONFIG_DATA-1:0] c_data;
    logic                         c_valid;
    logic                         c_UART_ready;
    logic                         c_VGA_ready;

    logic                         busy;
    logic                         done;
    logic                         err;
    logic [1:0]                   err_code;

    modport master (
        input  req_valid, req_addr, req_data,
        input  c_UART_ready, c_VGA_ready,
        output req_ready,
        output c_addr, c_data, c_valid,
        output busy, done, err, err_code
    );

    modport slave (
        output req_valid, req_addr, req_data,
        output c_UART_ready, c_VGA_ready,
        input  req_ready,
        input  c_addr, c_data, c_valid,
        input  busy, done, err, err_code
    );

endinterface

// File: rtl/cd_config_initiator_fifo.sv
// Small synchronous request queue with registered full/empty flags.
// Pointers wrap naturally because the depth is a power of two.
module cd_cfg_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; simultaneous ops cancel.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count - 1'b1;
        end
    end

    // Pointers, occupancy and flags, all derived from count_next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            empty <= (count_next == '0);
        end
    end

    // Storage array; contents need no reset since empty gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/cd_config_initiator.sv
// Config-bus initiator: queues requests, issues one c_valid strobe per
// request and follows the target ready handshake to done or error.
module cd_config_initiator #(
    parameter int WIDTH_CONFIG_ADDR = 2,
    parameter int WIDTH_CONFIG_DATA = 8,
    parameter int FIFO_DEPTH        = 4,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic              clk,
    input  logic              rst,
    cd_config_initiator_if.master bus
);

    import cd_config_initiator_pkg::*;

    localparam int A       = WIDTH_CONFIG_ADDR;
    localparam int D       = WIDTH_CONFIG_DATA;
    localparam int ENTRY_W = A + D;
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [A-1:0]  UART_A = A'(UART_BAUDRATE_ADDR);
    localparam logic [A-1:0]  VGA_A  = A'(VGA_RESOLUTION_ADDR);

    state_t           state;
    state_t           state_next;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic [A-1:0]     head_addr;
    logic [D-1:0]     head_data;

    logic [A-1:0]     c_addr_q;
    logic [D-1:0]     c_data_q;
    logic             c_valid_q;
    logic             done_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic [TW-1:0]    timer;

    logic             sel_ready;
    logic             timed_out;
    logic             latch;
    logic             done_set;
    logic             err_set;
    logic [1:0]       err_code_set;

    assign fifo_push = bus.req_valid && !fifo_full;
    assign fifo_din  = {bus.req_addr, bus.req_data};
    assign head_addr = fifo_dout[ENTRY_W-1:D];
    assign head_data = fifo_dout[D-1:0];

    cd_cfg_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready of the target addressed by the latched transaction.
    always_comb begin
        sel_ready = 1'b0;
        if (c_addr_q == UART_A) begin
            sel_ready = bus.c_UART_ready;
        end else if (c_addr_q == VGA_A) begin
            sel_ready = bus.c_VGA_ready;
        end
    end

    assign timed_out = (timer == T_LAST);

    // Transaction state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus pop/latch/done/err decisions for this cycle.
    always_comb begin
        state_next   = state;
        fifo_pop     = 1'b0;
        latch        = 1'b0;
        done_set     = 1'b0;
        err_set      = 1'b0;
        err_code_set = ERR_NONE;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (addr_ok(2'(head_addr))) begin
                        latch      = 1'b1;
                        state_next = ST_WAIT_RDY;
                    end else begin
                        err_set      = 1'b1;
                        err_code_set = ERR_BAD_ADDR;
                    end
                end
            end
            ST_WAIT_RDY: begin
                if (sel_ready) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!sel_ready) begin
                    state_next = ST_WAIT_DONE;
                end else if (timed_out) begin
                    err_set      = 1'b1;
                    err_code_set = ERR_TIMEOUT;
                    state_next   = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (sel_ready) begin
                    done_set   = 1'b1;
                    state_next = ST_IDLE;
                end else if (timed_out) begin
                    err_set      = 1'b1;
                    err_code_set = ERR_TIMEOUT;
                    state_next   = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake timer, shared by WAIT_ACK and WAIT_DONE, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state == ST_ISSUE) begin
            timer <= '0;
        end else if ((state == ST_WAIT_ACK || state == ST_WAIT_DONE) &&
                     !timed_out) begin
            timer <= timer + 1'b1;
        end
    end

    // Registered bus outputs and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_addr_q   <= '0;
            c_data_q   <= '0;
            c_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (latch) begin
                c_addr_q <= head_addr;
                c_data_q <= head_data;
            end
            c_valid_q <= (state_next == ST_ISSUE);
            done_q    <= done_set;
            err_q     <= err_set;
            if (err_set) begin
                err_code_q <= err_code_set;
            end
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.c_addr    = c_addr_q;
    assign bus.c_data    = c_data_q;
    assign bus.c_valid   = c_valid_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_cd_config_initiator.sv
// Scoreboard bench for cd_config_initiator with stub UART/VGA targets
// and a tiny model of the divider's baudrate/resolution registers.
module tb_cd_config_initiator;

    localparam int EV_ISSUE = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int         kind;
        logic [1:0] addr;
        logic [7:0] data;
        logic [1:0] code;
        int         lat;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cd_config_initiator_if #(
        .WIDTH_CONFIG_ADDR (2),
        .WIDTH_CONFIG_DATA (8)
    ) bus ();

    cd_config_initiator #(
        .WIDTH_CONFIG_ADDR (2),
        .WIDTH_CONFIG_DATA (8),
        .FIFO_DEPTH        (4),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   last_issue  = 0;
    int   acc_cyc     = 0;
    int   ack_hold    = 1;
    logic uart_stub   = 1'b1;
    logic vga_stub    = 1'b1;
    logic uart_block  = 1'b0;
    logic vga_hang    = 1'b0;
    logic [2:0] baud  = '0;
    logic [1:0] res   = '0;
    ev_t  sb[$];

    assign bus.c_UART_ready = uart_stub && !uart_block;
    assign bus.c_VGA_ready  = vga_stub;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [1:0] a,
                             input logic [7:0] d, input logic [1:0] c,
                             input int lat);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        e.code = c;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic take(input int kind, input string name);
        ev_t e;
        if (sb.size() == 0) begin
            chk({name, "_unexpected"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({name, "_kind"}, kind, e.kind);
        if (e.kind != kind) return;
        if (kind == EV_ISSUE) begin
            chk("issue_addr", bus.c_addr, e.addr);
            chk("issue_data", bus.c_data, e.data);
        end
        if (kind == EV_ERR) chk("err_code", bus.err_code, e.code);
        if (e.lat >= 0) chk({name, "_latency"}, cyc - last_issue, e.lat);
    endtask

    // Monitor: every DUT strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.c_valid) begin
                if (bus.c_addr == 2'b01) baud = bus.c_data[2:0];
                if (bus.c_addr == 2'b10) res  = bus.c_data[1:0];
                take(EV_ISSUE, "issue");
                last_issue = cyc;
            end
            if (bus.done || bus.err) chk("done_err_excl", bus.done && bus.err, 0);
            if (bus.done) take(EV_DONE, "done");
            if (bus.err) take(EV_ERR, "err");
        end
    end

    // UART stub: drops ready for ack_hold cycles after each strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.c_valid && bus.c_addr == 2'b01) begin
                uart_stub = 1'b0;
                repeat (ack_hold + 1) @(posedge clk);
                #1 uart_stub = 1'b1;
            end
        end
    end

    // VGA stub: same, unless told to hang with ready stuck high.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.c_valid && bus.c_addr == 2'b10 && !vga_hang) begin
                vga_stub = 1'b0;
                repeat (ack_hold + 1) @(posedge clk);
                #1 vga_stub = 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_req(input logic [1:0] a, input logic [7:0] d);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        while (!bus.req_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 60) chk("push_timeout", 1, 0);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", (n >= max_cyc) ? 1 : 0, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        // Reset state.
        #12;
        chk("rst_c_valid", bus.c_valid, 0);
        chk("rst_c_addr", bus.c_addr, 0);
        chk("rst_c_data", bus.c_data, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_err_code", bus.err_code, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single UART 19200 request: issue 2 cycles after pop, done at +3.
        expect_ev(EV_ISSUE, 2'b01, 8'h04, 2'b00, -1);
        expect_ev(EV_DONE, 2'b01, 8'h04, 2'b00, 3);
        push_req(2'b01, 8'h04);
        n = acc_cyc;
        drain(60);
        chk("pop_to_issue", last_issue - n, 3);
        chk("baud_19200", baud, 3'd4);

        // Five requests with UART ready held off: queue fills up.
        uart_block = 1'b1;
        expect_ev(EV_ISSUE, 2'b01, 8'h02, 2'b00, -1);
        expect_ev(EV_DONE, 2'b01, 8'h02, 2'b00, 3);
        expect_ev(EV_ISSUE, 2'b01, 8'h01, 2'b00, -1);
        expect_ev(EV_DONE, 2'b01, 8'h01, 2'b00, 3);
        expect_ev(EV_ISSUE, 2'b10, 8'h01, 2'b00, -1);
        expect_ev(EV_DONE, 2'b10, 8'h01, 2'b00, 3);
        expect_ev(EV_ISSUE, 2'b01, 8'h03, 2'b00, -1);
        expect_ev(EV_DONE, 2'b01, 8'h03, 2'b00, 3);
        expect_ev(EV_ISSUE, 2'b10, 8'h02, 2'b00, -1);
        expect_ev(EV_DONE, 2'b10, 8'h02, 2'b00, 3);
        push_req(2'b01, 8'h02);
        push_req(2'b01, 8'h01);
        push_req(2'b10, 8'h01);
        push_req(2'b01, 8'h03);
        push_req(2'b10, 8'h02);
        chk("full_req_ready", bus.req_ready, 0);
        chk("full_busy", bus.busy, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("full_hold_req_ready", bus.req_ready, 0);
        uart_block = 1'b0;
        drain(150);
        chk("req_ready_after", bus.req_ready, 1);
        chk("final_baud_9600", baud, 3'd3);
        chk("final_res_1024", res, 2'd2);

        // Bad addresses: two errors, nothing on the bus.
        expect_ev(EV_ERR, 2'b00, 8'h00, 2'b01, -1);
        expect_ev(EV_ERR, 2'b11, 8'h00, 2'b01, -1);
        push_req(2'b00, 8'h05);
        push_req(2'b11, 8'h01);
        drain(30);
        chk("bad_busy", bus.busy, 0);
        chk("bad_code_hold", bus.err_code, 2'b01);

        // VGA target never acks: decision 16 cycles after ISSUE,
        // registered err one cycle later; queued UART then completes.
        vga_hang = 1'b1;
        expect_ev(EV_ISSUE, 2'b10, 8'h01, 2'b00, -1);
        expect_ev(EV_ERR, 2'b10, 8'h01, 2'b10, 17);
        expect_ev(EV_ISSUE, 2'b01, 8'h03, 2'b00, -1);
        expect_ev(EV_DONE, 2'b01, 8'h03, 2'b00, 3);
        push_req(2'b10, 8'h01);
        push_req(2'b01, 8'h03);
        drain(100);
        vga_hang = 1'b0;
        chk("timeout_code_hold", bus.err_code, 2'b10);

        // UART ready low before and after the push: wait without timeout.
        uart_block = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        expect_ev(EV_ISSUE, 2'b01, 8'h01, 2'b00, -1);
        expect_ev(EV_DONE, 2'b01, 8'h01, 2'b00, 3);
        push_req(2'b01, 8'h01);
        repeat (20) @(posedge clk);
        #1;
        chk("wait_rdy_no_valid", bus.c_valid, 0);
        chk("wait_rdy_no_err", bus.err, 0);
        chk("wait_rdy_busy", bus.busy, 1);
        uart_block = 1'b0;
        n = cyc;
        drain(60);
        chk("rdy_to_issue", last_issue - n, 1);

        // Reset while in WAIT_DONE with two requests queued.
        ack_hold = 8;
        expect_ev(EV_ISSUE, 2'b01, 8'h04, 2'b00, -1);
        push_req(2'b01, 8'h04);
        push_req(2'b01, 8'h05);
        push_req(2'b01, 8'h06);
        n = 0;
        while (!bus.c_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_test_issue_seen", bus.c_valid, 1);
        repeat (3) @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b1;
        #1;
        chk("midrst_c_valid", bus.c_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("post_rst_busy", bus.busy, 0);
        ack_hold = 1;
        expect_ev(EV_ISSUE, 2'b01, 8'h01, 2'b00, -1);
        expect_ev(EV_DONE, 2'b01, 8'h01, 2'b00, 3);
        push_req(2'b01, 8'h01);
        drain(60);
        chk("post_rst_baud", baud, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
